// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store initiator for a word-addressed data memory.
//                Handles byte/half/word accesses with sign/zero-extended
//                loads and read-modify-write for sub-word stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [31:0]   mem_dout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD     = 2'd1;
    localparam logic [1:0] ST_RMW_RD = 2'd2;
    localparam logic [1:0] ST_WR     = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // The access direction is fully encoded by the state sequence, so the
    // latched request only keeps size, extension mode, address and data.
    logic [1:0]    state_q,  state_d;
    logic [1:0]    size_q,   size_d;
    logic          sext_q,   sext_d;
    logic [AW+1:0] addr_q,   addr_d;
    logic [31:0]   wdata_q,  wdata_d;
    logic          done_q,   done_d;
    logic          err_q,    err_d;
    logic [31:0]   rdata_q,  rdata_d;
    logic [31:0]   mem_din_q, mem_din_d;

    logic          w_misaligned;
    logic [4:0]    w_lane_shift;
    logic [31:0]   w_lane_data;
    logic [31:0]   w_lane_mask;
    logic [31:0]   w_load_ext;
    logic [31:0]   w_store_merge;
    logic          w_unused_addr;

    // Upper address bits alias onto the memory window and are deliberately dropped.
    assign w_unused_addr = ^addr[31:AW+2];

    // Request legality check on the raw inputs, evaluated at accept time.
    always_comb begin
        w_misaligned = 1'b0;
        case (size)
            SZ_HALF: w_misaligned = addr[0];
            SZ_WORD: w_misaligned = (addr[1:0] != 2'b00);
            SZ_BYTE: w_misaligned = 1'b0;
            default: w_misaligned = 1'b1;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        w_lane_shift  = {addr_q[1:0], 3'b000};
        w_lane_data   = mem_dout >> w_lane_shift;
        w_lane_mask   = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << w_lane_shift;
        w_store_merge = (mem_dout & ~w_lane_mask) | ((wdata_q << w_lane_shift) & w_lane_mask);
        case (size_q)
            SZ_BYTE: w_load_ext = sext_q ? {{24{w_lane_data[7]}}, w_lane_data[7:0]}
                                         : {24'h0, w_lane_data[7:0]};
            SZ_HALF: w_load_ext = sext_q ? {{16{w_lane_data[15]}}, w_lane_data[15:0]}
                                         : {16'h0, w_lane_data[15:0]};
            default: w_load_ext = mem_dout;
        endcase
    end

    // State and datapath registers; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            size_q    <= 2'b00;
            sext_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            mem_din_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            mem_din_q <= mem_din_d;
        end
    end

    // Next-state and next-data logic.
    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        sext_d    = sext_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        mem_din_d = mem_din_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    size_d  = size;
                    sext_d  = sext;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    if (w_misaligned) begin
                        // Rejected requests complete immediately without touching memory.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (!wr) begin
                        state_d = ST_RD;
                    end else if (size == SZ_WORD) begin
                        state_d   = ST_WR;
                        mem_din_d = wdata;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                rdata_d = w_load_ext;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RMW_RD: begin
                mem_din_d = w_store_merge;
                state_d   = ST_WR;
            end
            ST_WR: begin
                done_d    = 1'b1;
                mem_din_d = 32'h0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        mem_re = (state_q == ST_RD) || (state_q == ST_RMW_RD);
        mem_we = (state_q == ST_WR);
    end

    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign mem_din  = mem_din_q;
    assign mem_addr = addr_q[AW+1:2];

endmodule
`default_nettype wire
